// File: rtl/data_mem_pkg.sv
// Shared constants, encodings and lane helpers for the handshaked RV32 data memory.
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Byte lanes touched by a store of the given width at the given word offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (funct3)
            F3_B:    m = 4'b0001 << addr_lo;
            F3_H:    m = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: funct3 legality, alignment, store merge and load extension.
module lsu_align
    import data_mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        illegal,
    output logic        misalign,
    output logic [3:0]  wmask,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    logic [31:0] wrep_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Legality and alignment; unsigned variants exist only for loads.
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        case (funct3)
            F3_B:    misalign = 1'b0;
            F3_H:    misalign = addr_lo[0];
            F3_W:    misalign = |addr_lo;
            F3_BU: begin
                illegal  = we;
                misalign = 1'b0;
            end
            F3_HU: begin
                illegal  = we;
                misalign = addr_lo[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Replicate store data across lanes, then merge the selected lanes into the old word.
    always_comb begin
        wmask = we ? lane_mask(funct3, addr_lo) : 4'b0000;
        case (funct3)
            F3_B:    wrep_s = {4{wdata[7:0]}};
            F3_H:    wrep_s = {2{wdata[15:0]}};
            default: wrep_s = wdata;
        endcase
        for (int i = 0; i < 4; i++) begin
            wword[8*i +: 8] = wmask[i] ? wrep_s[8*i +: 8] : rword[8*i +: 8];
        end
    end

    // Pick the addressed lane and extend it.
    always_comb begin
        byte_s = rword[{addr_lo, 3'b000} +: 8];
        half_s = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (funct3)
            F3_B:    ldata = {{24{byte_s[7]}}, byte_s};
            F3_BU:   ldata = {24'h000000, byte_s};
            F3_H:    ldata = {{16{half_s[15]}}, half_s};
            F3_HU:   ldata = {16'h0000, half_s};
            F3_W:    ldata = rword;
            default: ldata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_hs.sv
// Handshaked RV32I data memory: one outstanding access, checked before touching RAM,
// with a configurable load latency.
module data_mem_hs
    import data_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    MEM_WORDS    = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h0000_0000),
    parameter int                    READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_err
);

    localparam int                    IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);
    localparam logic [2:0]            CNT_INIT  = 3'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;

    logic [31:0] mem_q [MEM_WORDS];

    logic [ADDR_WIDTH-1:0] offset_s;
    logic [IDX_W-1:0]      idx_s;
    logic [31:0]           rword_s, wword_s, ldata_s;
    logic [3:0]            wmask_s;
    logic                  illegal_s, misalign_s, in_range_s;
    logic                  accept_s, load_ok_s, write_en_s;
    err_e                  err_s;

    // Offset from the base makes the range test a single unsigned compare, so nothing aliases.
    assign offset_s   = req_addr - BASE_ADDR;
    assign idx_s      = offset_s[IDX_W+1:2];
    assign in_range_s = offset_s < MEM_BYTES;
    assign rword_s    = mem_q[idx_s];
    assign accept_s   = req_valid && req_ready_q;

    lsu_align u_align (
        .we       (req_we),
        .funct3   (req_funct3),
        .addr_lo  (offset_s[1:0]),
        .wdata    (req_wdata),
        .rword    (rword_s),
        .illegal  (illegal_s),
        .misalign (misalign_s),
        .wmask    (wmask_s),
        .wword    (wword_s),
        .ldata    (ldata_s)
    );

    // Error priority: illegal funct3, then range, then alignment.
    always_comb begin
        if (illegal_s) begin
            err_s = ERR_ILLEGAL;
        end else if (!in_range_s) begin
            err_s = ERR_RANGE;
        end else if (misalign_s) begin
            err_s = ERR_MISALIGN;
        end else begin
            err_s = ERR_OK;
        end
    end

    assign load_ok_s  = !req_we && (err_s == ERR_OK);
    assign write_en_s = accept_s && req_we && (err_s == ERR_OK) && (|wmask_s);

    // State, counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 2'b00;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next state; the response payload is captured at acceptance and held until handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    rsp_err_d   = err_s;
                    rsp_rdata_d = load_ok_s ? ldata_s : 32'h0000_0000;
                    if (load_ok_s && (CNT_INIT != 3'd0)) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Handshake flags decoded from the next state so they leave the block registered.
    always_comb begin
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_d)
            IDLE:    req_ready_d = 1'b1;
            WAIT:    req_ready_d = 1'b0;
            RESP:    rsp_valid_d = 1'b1;
            default: req_ready_d = 1'b0;
        endcase
    end

    // Data RAM: not reset, so stored data survives a reset.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            mem_q[idx_s] <= wword_s;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench for data_mem_hs: directed vector table, reset corner cases and
// randomised traffic against a byte-array reference model.
module tb_data_mem_hs;

    localparam int RL        = 3;
    localparam int MEM_BYTES = 256;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int n_checks;
    int n_errors;

    logic [7:0] ref_mem [MEM_BYTES];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  er;
        int          hold;
    } vec_t;

    vec_t tbl [$];

    data_mem_hs #(
        .ADDR_WIDTH   (32),
        .MEM_WORDS    (64),
        .BASE_ADDR    (32'h0000_0000),
        .READ_LATENCY (RL)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: RV32I load/store semantics over a flat byte array.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] er);
        int          size;
        bit          sgn;
        bit          legal;
        logic [31:0] v;
        size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
        sgn   = (f3 == 3'd0 || f3 == 3'd1);
        legal = we ? (f3 <= 3'd2) : (size != 0);
        if (!legal)                              er = 2'd3;
        else if (addr >= 32'(MEM_BYTES))         er = 2'd2;
        else if ((addr % 32'(size)) != 32'd0)    er = 2'd1;
        else                                     er = 2'd0;
        rd = 32'h0;
        if (er == 2'd0) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr + 32'(i)];
                if (sgn && v[8*size-1]) begin
                    for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                rd = v;
            end
        end
    endtask

    // One full transaction with response held back for 'hold' cycles.
    task automatic access(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          input logic [31:0] exp_rd, input logic [1:0] exp_er);
        int lat;
        int exp_lat;
        exp_lat = (!we && exp_er == 2'd0) ? RL : 1;
        @(negedge clk);
        chk({nm, ":req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 16) begin
            chk({nm, ":req_ready_wait"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk({nm, ":latency"}, 32'(lat), 32'(exp_lat));
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            chk({nm, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, ":rsp_rdata"}, rsp_rdata, exp_rd);
            chk({nm, ":rsp_err"}, 32'(rsp_err), 32'(exp_er));
            chk({nm, ":req_ready_resp"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, ":rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
        chk({nm, ":req_ready_after_hs"}, 32'(req_ready), 32'd1);
    endtask

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] er, input int hold);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.er = er; v.hold = hold;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] m_rd;
        logic [1:0]  m_er;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          n;

        n_checks = 0;
        n_errors = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;

        // Directed vectors: {we, funct3, addr, wdata, expected rdata, expected err, hold}
        add(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        2'd0, 1);
        add(1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 2'd0, 1);
        add(1'b0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 2'd0, 1);
        add(1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 2'd0, 1);
        add(1'b0, 3'd5, 32'h12, 32'h0,        32'h0000DEAD, 2'd0, 1);
        add(1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 2'd0, 5);
        add(1'b0, 3'd0, 32'h10, 32'h0,        32'hFFFFFFEF, 2'd0, 0);
        add(1'b0, 3'd4, 32'h11, 32'h0,        32'h000000BE, 2'd0, 0);
        add(1'b0, 3'd1, 32'h10, 32'h0,        32'hFFFFBEEF, 2'd0, 0);
        add(1'b1, 3'd0, 32'h11, 32'hAAAAAA55, 32'h0,        2'd0, 1);
        add(1'b0, 3'd2, 32'h10, 32'h0,        32'hDEAD55EF, 2'd0, 1);
        add(1'b1, 3'd1, 32'h12, 32'hFFFF1234, 32'h0,        2'd0, 1);
        add(1'b0, 3'd2, 32'h10, 32'h0,        32'h123455EF, 2'd0, 1);
        add(1'b0, 3'd2, 32'h12, 32'h0,        32'h0,        2'd1, 1);
        add(1'b1, 3'd2, 32'h12, 32'h0,        32'h0,        2'd1, 1);
        add(1'b1, 3'd1, 32'h13, 32'h0,        32'h0,        2'd1, 0);
        add(1'b0, 3'd5, 32'h11, 32'h0,        32'h0,        2'd1, 0);
        add(1'b0, 3'd2, 32'h10, 32'h0,        32'h123455EF, 2'd0, 0);
        add(1'b1, 3'd2, 32'h00, 32'hCAFEF00D, 32'h0,        2'd0, 0);
        add(1'b1, 3'd2, 32'h100, 32'h11111111, 32'h0,       2'd2, 1);
        add(1'b0, 3'd2, 32'h00, 32'h0,        32'hCAFEF00D, 2'd0, 0);
        add(1'b0, 3'd3, 32'h101, 32'h0,       32'h0,        2'd3, 1);
        add(1'b0, 3'd6, 32'h10, 32'h0,        32'h0,        2'd3, 0);
        add(1'b1, 3'd4, 32'h10, 32'h0,        32'h0,        2'd3, 0);
        add(1'b1, 3'd7, 32'h10, 32'h0,        32'h0,        2'd3, 0);
        add(1'b0, 3'd2, 32'h10, 32'h0,        32'h123455EF, 2'd0, 0);
        add(1'b1, 3'd2, 32'hFC, 32'h0BADF00D, 32'h0,        2'd0, 0);
        add(1'b0, 3'd2, 32'hFC, 32'h0,        32'h0BADF00D, 2'd0, 0);
        add(1'b0, 3'd4, 32'hFF, 32'h0,        32'h0000000B, 2'd0, 0);
        add(1'b0, 3'd0, 32'h100, 32'h0,       32'h0,        2'd2, 0);
        add(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,  32'h0,        2'd2, 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset:req_ready", 32'(req_ready), 32'd1);
        chk("reset:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset:rsp_err", 32'(rsp_err), 32'd0);
        chk("reset:rsp_rdata", rsp_rdata, 32'h0);
        for (int i = 0; i < 5; i++) begin
            req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
            @(negedge clk);
            chk("idle:rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle:req_ready", 32'(req_ready), 32'd1);
        end

        // Give every word a known value.
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            model(1'b1, 3'd2, 32'(w * 4), wd, m_rd, m_er);
            access("init", 1'b1, 3'd2, 32'(w * 4), wd, 0, m_rd, m_er);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, m_rd, m_er);
            access($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                   tbl[i].hold, tbl[i].rd, tbl[i].er);
        end

        // Reset while a load is counting down: the load is dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_wait:rsp_valid_before", 32'(rsp_valid), 32'd0);
        chk("rst_wait:req_ready_before", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("rst_wait:rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < RL + 2; i++) begin
            @(negedge clk);
            chk("rst_wait:rsp_valid_after", 32'(rsp_valid), 32'd0);
            chk("rst_wait:req_ready_after", 32'(req_ready), 32'd1);
        end

        // Reset while a response is pending: outputs clear at once, RAM keeps its data.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("rst_resp:rsp_rdata_before", rsp_rdata, 32'h123455EF);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_resp:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp:rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_resp:rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_resp:rsp_valid_after", 32'(rsp_valid), 32'd0);
        chk("rst_resp:req_ready_after", 32'(req_ready), 32'd1);
        model(1'b0, 3'd2, 32'h10, 32'h0, m_rd, m_er);
        access("ram_survives", 1'b0, 3'd2, 32'h10, 32'h0, 0, m_rd, m_er);

        // Randomised mix with back-pressure.
        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom);
            end else begin
                n  = $urandom_range(0, we ? 2 : 4);
                f3 = (n < 3) ? 3'(n) : 3'(n + 1);
            end
            a = 32'($urandom_range(0, 67)) * 32'd4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3 == 3'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 19) == 0) a = $urandom;
            wd = $urandom;
            model(we, f3, a, wd, m_rd, m_er);
            access($sformatf("rand%0d", k), we, f3, a, wd, $urandom_range(0, 3), m_rd, m_er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
